// File: rtl/dispatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dispatch_pkg
//  Description : Types and constants shared between the instruction fetch
//                queue and the dispatch unit.
//                  INSTR_WIDTH      - instruction / PC / address width
//                  RESET_PC_DEFAULT - PC loaded when reset is asserted
//                  ifq_entry_t      - one queued {pc, instr} pair
//  Revision    : 1.0 - initial release
// ============================================================================
package dispatch_pkg;

    localparam int                     INSTR_WIDTH      = 32;
    localparam logic [INSTR_WIDTH-1:0] RESET_PC_DEFAULT = '0;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] pc;
        logic [INSTR_WIDTH-1:0] instr;
    } ifq_entry_t;

endpackage : dispatch_pkg
`default_nettype wire

// File: rtl/instruction_fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_queue_if
//  Description : Bundles the dispatch-side and instruction-memory-side
//                signals of the instruction fetch queue.
//                  master - the environment (dispatch stage + imem model)
//                  slave  - the fetch queue itself
//                Dispatch side : Read_enable, jump_branch_valid,
//                                jump_branch_address -> queue
//                                Instruction, PC_out, empty <- queue
//                Memory side   : imem_rd_en, imem_addr <- queue
//                                imem_rdata -> queue (1-cycle latency)
//  Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_queue_if #(
    parameter int DATA_WIDTH = 32
);

    logic                  Read_enable;
    logic                  jump_branch_valid;
    logic [DATA_WIDTH-1:0] jump_branch_address;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  imem_rd_en;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] Instruction;
    logic [DATA_WIDTH-1:0] PC_out;
    logic                  empty;

    modport master (
        output Read_enable, jump_branch_valid, jump_branch_address, imem_rdata,
        input  imem_rd_en, imem_addr, Instruction, PC_out, empty
    );

    modport slave (
        input  Read_enable, jump_branch_valid, jump_branch_address, imem_rdata,
        output imem_rd_en, imem_addr, Instruction, PC_out, empty
    );

endinterface : instruction_fetch_queue_if
`default_nettype wire

// File: rtl/ifq_storage.sv
`default_nettype none
// ============================================================================
//  Module      : ifq_storage
//  Description : DEPTH-entry register array of {pc, instr} pairs.
//                  clk     - write clock
//                  wr_en   - write wr_data at wr_ptr on the rising edge
//                  wr_ptr  - write index
//                  wr_data - entry to store
//                  rd_ptr  - read index
//                  rd_data - entry at rd_ptr (combinational)
//                Contents are not reset; the owner gates the read data with
//                its own occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifq_storage
    import dispatch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  wire logic       clk,
    input  wire logic       wr_en,
    input  wire logic [PW-1:0] wr_ptr,
    input  wire ifq_entry_t wr_data,
    input  wire logic [PW-1:0] rd_ptr,
    output      ifq_entry_t rd_data
);

    ifq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule : ifq_storage
`default_nettype wire

// File: rtl/instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_queue
//  Description : Keeps the PC, issues fetches to a synchronous-read
//                instruction memory and buffers {PC, instruction} pairs in a
//                first-word-fall-through queue for the dispatch stage.
//                  clk   - single clock, rising edge
//                  reset - asynchronous, active-high
//                  bus   - dispatch handshake and imem request/response
//                          (see instruction_fetch_queue_if)
//                A redirect flushes the queue, cancels the in-flight fetch
//                and reloads the PC with the word-aligned target.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_queue
    import dispatch_pkg::*;
#(
    parameter  int                    DATA_WIDTH = INSTR_WIDTH,
    parameter  int                    DEPTH      = 4,
    parameter  logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
    localparam int                    PW         = $clog2(DEPTH),
    localparam int                    CW         = PW + 1
) (
    input  wire logic                clk,
    input  wire logic                reset,
    instruction_fetch_queue_if.slave bus
);

    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inflight_pc;
    logic                  inflight;
    logic [CW-1:0]         count;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    logic                  redirect;
    logic                  issue;
    logic                  fill;
    logic                  pop;
    logic                  is_empty;
    logic [CW-1:0]         occupancy;
    ifq_entry_t            wr_data;
    ifq_entry_t            head;

    assign redirect = bus.jump_branch_valid;
    assign is_empty = (count == '0);

    // The in-flight word already owns a slot, so it is counted as occupied.
    // A pop this cycle is deliberately not credited until the next cycle.
    assign occupancy = count + CW'(inflight);
    assign issue     = !reset && !redirect && (occupancy < CW'(DEPTH));

    // Redirect kills both the returning word and any pop in the same cycle.
    assign fill = inflight && !redirect;
    assign pop  = bus.Read_enable && !is_empty && !redirect;

    assign wr_data.pc    = inflight_pc;
    assign wr_data.instr = bus.imem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redirect) begin
            pc       <= {bus.jump_branch_address[DATA_WIDTH-1:2], 2'b00};
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + DATA_WIDTH'(4);
            end
            if (fill) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({fill, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    ifq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk     (clk),
        .wr_en   (fill),
        .wr_ptr  (wr_ptr),
        .wr_data (wr_data),
        .rd_ptr  (rd_ptr),
        .rd_data (head)
    );

    assign bus.imem_rd_en  = issue;
    assign bus.imem_addr   = pc;
    assign bus.empty       = is_empty;
    assign bus.Instruction = is_empty ? '0 : head.instr;
    assign bus.PC_out      = is_empty ? '0 : head.pc;

endmodule : instruction_fetch_queue
`default_nettype wire

// File: tb/tb_instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch_queue
//  Description : Self-checking bench for instruction_fetch_queue. A queue of
//                {pc, instr} pairs plus a single pending-fetch record predicts
//                every output each cycle; the memory model returns addr+0x1000.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_queue;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    instruction_fetch_queue_if #(.DATA_WIDTH(DW)) bus ();

    instruction_fetch_queue #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous-read instruction memory: word = address + 0x1000.
    always @(posedge clk) begin
        bus.imem_rdata <= bus.imem_rd_en ? bus.imem_addr + 32'h1000 : 32'hDEAD_BEEF;
    end

    int total = 0;
    int bad   = 0;

    // Reference state: what the queue should hold, what is on its way, next PC.
    logic [31:0] m_pc;
    logic [31:0] m_pend_pc;
    bit          m_pend;
    logic [31:0] q_pc [$];
    logic [31:0] q_in [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = 32'h0;
        m_pend    = 1'b0;
        m_pend_pc = 32'h0;
        q_pc.delete();
        q_in.delete();
    endtask

    function automatic bit model_fetch(input bit rst, input bit jb);
        return !rst && !jb && ((q_pc.size() + int'(m_pend)) < DEPTH);
    endfunction

    task automatic check_outputs(input bit jb);
        bit          e;
        bit          emp;
        logic [31:0] hp;
        logic [31:0] hi;
        e   = model_fetch(reset, jb);
        emp = (q_pc.size() == 0);
        hp  = emp ? 32'h0 : q_pc[0];
        hi  = emp ? 32'h0 : q_in[0];
        chk("imem_rd_en",  {31'b0, bus.imem_rd_en}, {31'b0, e});
        chk("imem_addr",   bus.imem_addr, m_pc);
        chk("empty",       {31'b0, bus.empty}, {31'b0, emp});
        chk("PC_out",      bus.PC_out, hp);
        chk("Instruction", bus.Instruction, hi);
    endtask

    task automatic model_update(input bit re, input bit jb, input logic [31:0] tgt);
        bit e;
        if (reset) begin
            model_reset();
        end else if (jb) begin
            q_pc.delete();
            q_in.delete();
            m_pend = 1'b0;
            m_pc   = {tgt[31:2], 2'b00};
        end else begin
            e = model_fetch(1'b0, 1'b0);
            // The word landing this edge cannot be the one popped this edge.
            if (re && q_pc.size() > 0) begin
                void'(q_pc.pop_front());
                void'(q_in.pop_front());
            end
            if (m_pend) begin
                q_pc.push_back(m_pend_pc);
                q_in.push_back(m_pend_pc + 32'h1000);
            end
            m_pend = e;
            if (e) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
        end
    endtask

    // One clock: drive at the falling edge, check just after, advance model at
    // the rising edge.
    task automatic step(input bit re, input bit jb, input logic [31:0] tgt);
        bus.Read_enable         = re;
        bus.jump_branch_valid   = jb;
        bus.jump_branch_address = tgt;
        #1;
        check_outputs(jb);
        @(posedge clk);
        model_update(re, jb, tgt);
        @(negedge clk);
    endtask

    initial begin
        reset                   = 1'b1;
        bus.Read_enable         = 1'b0;
        bus.jump_branch_valid   = 1'b0;
        bus.jump_branch_address = 32'h0;
        model_reset();
        @(negedge clk);
        step(0, 0, 0);
        step(0, 0, 0);
        reset = 1'b0;

        // Start-up, then fill to capacity with no pops.
        for (int i = 0; i < 8; i++) step(0, 0, 0);
        chk("full_q_size", q_pc.size(), 32'd4);
        chk("full_q_last", q_pc[3], 32'hC);

        // Drain with Read_enable held; refetch continues from 0x10.
        for (int i = 0; i < 8; i++) step(1, 0, 0);

        // Flush, then rebuild 2 entries + 1 in flight and redirect to 0x103.
        step(0, 1, 32'h200);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        step(0, 1, 32'h103);
        chk("redir_pc", m_pc, 32'h100);
        for (int i = 0; i < 4; i++) step(0, 0, 0);

        // Pop together with redirect, then pop while empty.
        step(1, 1, 32'h300);
        step(1, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);

        // Mid-stream reset with entries queued.
        step(0, 1, 32'h400);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        reset = 1'b1;
        model_reset();
        step(1, 0, 0);
        step(0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step(0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            if (($urandom % 80) == 0) begin
                reset = 1'b1;
                model_reset();
                step(bit'($urandom % 2), 0, 0);
                reset = 1'b0;
            end else begin
                step(($urandom % 4) != 0, ($urandom % 12) == 0, $urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instruction_fetch_queue
`default_nettype wire
